// File: rtl/fp_align_serial.sv
// fp_align_serial: orders two packed IEEE-754 operands by magnitude and right-aligns the smaller significand.
// Define FP_ALIGN_STICKY_EN to OR every bit shifted past bit 0 into the sticky bit.
module fp_align_serial #(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    parameter  int STEP  = 4,
    localparam int W     = 1 + EXP_W + MAN_W,
    localparam int SW    = MAN_W + 4,
    localparam int CW    = $clog2(MAN_W + 5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             swap,
    output logic             res_sign,
    output logic             eff_sub,
    output logic [EXP_W-1:0] res_exp,
    output logic [SW-1:0]    big_man,
    output logic [SW-1:0]    small_man
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d, s, diff_c;
    logic [SW-1:0]    small_q, small_d, big_q, big_d, sh, shifted;
    logic [EXP_W-1:0] exp_q, exp_d, eff_big, eff_small, diff;
    logic             swap_q, swap_d, sign_q, sign_d, sub_q, sub_d, sw;
    logic [W-1:0]     big_op, small_op;

    assign sw        = op_a[W-2:0] < op_b[W-2:0];
    assign big_op    = sw ? op_b : op_a;
    assign small_op  = sw ? op_a : op_b;
    assign eff_big   = big_op[W-2:MAN_W] == '0 ? EXP_W'(1) : big_op[W-2:MAN_W];
    assign eff_small = small_op[W-2:MAN_W] == '0 ? EXP_W'(1) : small_op[W-2:MAN_W];
    assign diff      = eff_big - eff_small;
    assign diff_c    = 32'(diff) > SW ? CW'(SW) : CW'(diff);
    assign s         = rem_q < CW'(STEP) ? rem_q : CW'(STEP);
    assign sh        = small_q >> s;
`ifdef FP_ALIGN_STICKY_EN
    // Bit 0 of the mask covers the old sticky, so it is carried forward too.
    assign shifted   = {sh[SW-1:1], sh[0] | (|(small_q & ~({SW{1'b1}} << s)))};
`else
    assign shifted   = sh;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        small_d = small_q;
        big_d   = big_q;
        exp_d   = exp_q;
        swap_d  = swap_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        if (state_q == IDLE && in_valid) begin
            swap_d  = sw;
            sign_d  = big_op[W-1];
            sub_d   = op_a[W-1] ^ op_b[W-1];
            exp_d   = big_op[W-2:MAN_W];
            big_d   = {|big_op[W-2:MAN_W], big_op[MAN_W-1:0], 3'b000};
            small_d = {|small_op[W-2:MAN_W], small_op[MAN_W-1:0], 3'b000};
            rem_d   = diff_c;
            state_d = diff_c == '0 ? DONE : SHIFT;
        end else if (state_q == SHIFT) begin
            small_d = shifted;
            rem_d   = rem_q - s;
            state_d = rem_q == s ? DONE : SHIFT;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            small_q <= '0;
            big_q   <= '0;
            exp_q   <= '0;
            swap_q  <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            small_q <= small_d;
            big_q   <= big_d;
            exp_q   <= exp_d;
            swap_q  <= swap_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign swap      = swap_q;
    assign res_sign  = sign_q;
    assign eff_sub   = sub_q;
    assign res_exp   = exp_q;
    assign big_man   = big_q;
    assign small_man = small_q;
endmodule

// File: tb/tb_fp_align_serial.sv
// tb_fp_align_serial: randomized and directed check of fp_align_serial against a whole-shift reference model.
module tb_fp_align_serial;
    localparam int EW = 5, MW = 10, SW = MW + 4, W = 1 + EW + MW, STEP = 4;

    logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic in_ready, out_valid, swap, res_sign, eff_sub;
    logic [EW-1:0] res_exp;
    logic [SW-1:0] big_man, small_man;
    int total = 0, bad = 0, cyc = 0;

    typedef struct {
        logic sw, sg, sub;
        logic [EW-1:0] e;
        logic [SW-1:0] bm, sm;
        int lat, acc;
    } res_t;
    res_t q[$];

    fp_align_serial #(.EXP_W(EW), .MAN_W(MW), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .swap(swap), .res_sign(res_sign),
        .eff_sub(eff_sub), .res_exp(res_exp), .big_man(big_man), .small_man(small_man));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
        end
    endtask

    // Shift the whole distance in one go; sticky is simply "any lost bit set".
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        int ea, eb, fa, fb, ma, mb, xa, xb, big, sml, d, lost;
        ea = int'(a[W-2:MW]); eb = int'(b[W-2:MW]);
        fa = int'(a[MW-1:0]); fb = int'(b[MW-1:0]);
        ma = ea * (1 << MW) + fa; mb = eb * (1 << MW) + fb;
        r.sw = ma < mb;
        xa = (ea == 0) ? 1 : ea; xb = (eb == 0) ? 1 : eb;
        big = ((ea != 0) ? (1 << MW) + fa : fa) * 8;
        sml = ((eb != 0) ? (1 << MW) + fb : fb) * 8;
        d = xa - xb;
        r.e = a[W-2:MW]; r.sg = a[W-1];
        if (r.sw) begin
            big = ((eb != 0) ? (1 << MW) + fb : fb) * 8;
            sml = ((ea != 0) ? (1 << MW) + fa : fa) * 8;
            d = xb - xa; r.e = b[W-2:MW]; r.sg = b[W-1];
        end
        if (d > SW) d = SW;
        lost = sml % (1 << d);
        sml = sml >> d;
`ifdef FP_ALIGN_STICKY_EN
        if (lost != 0) sml = sml | 1;
`endif
        r.sub = a[W-1] ^ b[W-1];
        r.bm = SW'(big); r.sm = SW'(sml);
        r.lat = (d == 0) ? 1 : 1 + (d + STEP - 1) / STEP;
        r.acc = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_flags", 32'({swap, res_sign, eff_sub}), 0);
            chk("rst_res_exp", 32'(res_exp), 0);
            chk("rst_big_man", 32'(big_man), 0);
            chk("rst_small_man", 32'(small_man), 0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0 && cyc - q[0].acc >= q[0].lat));
            if (out_valid && q.size() != 0) begin
                chk("swap", 32'(swap), 32'(q[0].sw));
                chk("res_sign", 32'(res_sign), 32'(q[0].sg));
                chk("eff_sub", 32'(eff_sub), 32'(q[0].sub));
                chk("res_exp", 32'(res_exp), 32'(q[0].e));
                chk("big_man", 32'(big_man), 32'(q[0].bm));
                chk("small_man", 32'(small_man), 32'(q[0].sm));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                res_t e;
                e = model(op_a, op_b);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic xfer(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, output res_t r);
        int n;
        @(posedge clk); #1;
        op_a = a; op_b = b; in_valid = 1; out_ready = 0;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
        r.lat = 1;
        while (!out_valid && r.lat < 50) begin @(posedge clk); #1; r.lat++; end
        if (r.lat >= 50) chk("valid_timeout", 0, 1);
        r.sw = swap; r.sg = res_sign; r.sub = eff_sub; r.e = res_exp; r.bm = big_man; r.sm = small_man;
        repeat (hold) begin
            op_a = W'($urandom); op_b = W'($urandom); in_valid = 1;
            @(posedge clk); #1;
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_small_man", 32'(small_man), 32'(r.sm));
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_after", 32'(in_ready), 1);
    endtask

    initial begin
        res_t r, m;
        logic [W-1:0] a, b;
        logic [SW-1:0] exp3, exp4;
`ifdef FP_ALIGN_STICKY_EN
        exp3 = 14'h0201; exp4 = 14'h0001;
`else
        exp3 = 14'h0200; exp4 = 14'h0000;
`endif
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        m = model(16'h4C00, 16'h3C01);
        chk("model_sm3", 32'(m.sm), 32'(exp3));
        chk("model_lat3", 32'(m.lat), 2);
        m = model(16'h7800, 16'h8001);
        chk("model_lat4", 32'(m.lat), 5);
        chk("model_sm4", 32'(m.sm), 32'(exp4));

        xfer(16'h3C00, 16'h3C00, 0, r);
        chk("t1_swap", 32'(r.sw), 0);
        chk("t1_exp", 32'(r.e), 32'h0F);
        chk("t1_big", 32'(r.bm), 32'h2000);
        chk("t1_small", 32'(r.sm), 32'h2000);
        chk("t1_sub", 32'(r.sub), 0);
        chk("t1_lat", 32'(r.lat), 1);

        xfer(16'h3C00, 16'h4000, 3, r);
        chk("t2_swap", 32'(r.sw), 1);
        chk("t2_exp", 32'(r.e), 32'h10);
        chk("t2_big", 32'(r.bm), 32'h2000);
        chk("t2_small", 32'(r.sm), 32'h1000);
        chk("t2_lat", 32'(r.lat), 2);

        xfer(16'h4C00, 16'h3C01, 0, r);
        chk("t3_small", 32'(r.sm), 32'(exp3));
        chk("t3_lat", 32'(r.lat), 2);

        xfer(16'h7800, 16'h8001, 1, r);
        chk("t4_small", 32'(r.sm), 32'(exp4));
        chk("t4_sub", 32'(r.sub), 1);
        chk("t4_sign", 32'(r.sg), 0);
        chk("t4_lat", 32'(r.lat), 5);

        @(posedge clk); #1;
        op_a = 16'h7800; op_b = 16'h8001; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_small", 32'(small_man), 0);
        chk("mid_rst_big", 32'(big_man), 0);
        chk("mid_rst_exp", 32'(res_exp), 0);
        @(posedge clk); #1;
        rst = 0;
        xfer(16'h3C00, 16'h3C00, 0, r);
        chk("post_rst_small", 32'(r.sm), 32'h2000);
        chk("post_rst_lat", 32'(r.lat), 1);

        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i % 2 == 0) b[W-2:MW] = a[W-2:MW] + EW'($urandom_range(0, 6)) - EW'(3);
            if (i % 7 == 0) a[W-2:MW] = '0;
            if (i % 11 == 0) b = a;
            xfer(a, b, int'($urandom_range(0, 3)), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_align_serial.md
# fp_align_serial

Parametrised floating-point operand alignment unit for the adder datapath; successor to the combinational half-precision arrange stage. It accepts two packed IEEE-754 operands over a valid/ready handshake and orders them by full magnitude. The smaller significand is right-shifted by the exponent difference using an iterative shifter of configurable width per cycle, with guard/round/sticky bits. It then presents the aligned significands, result exponent/sign and effective-operation flag to the downstream add/normalise stage.

## Interface
- EXP_W, 5, exponent field width
- MAN_W, 10, stored fraction width; operand width W = 1+EXP_W+MAN_W
- STEP, 4, max shift distance per cycle; legal range 1..MAN_W+4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_a, op_b  in  W each  packed operands {sign, exp, frac}
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept (high only in IDLE)
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- swap  out  1  1 when op_b had larger magnitude
- res_sign  out  1  sign of larger-magnitude operand
- eff_sub  out  1  sign_a XOR sign_b
- res_exp  out  EXP_W  raw exponent field of larger operand
- big_man  out  MAN_W+4  {hidden, frac, 3'b000}
- small_man  out  MAN_W+4  aligned smaller significand {hidden, frac, G, R, S} after shift

## Operation
- FSM states IDLE, SHIFT, DONE; reset -> IDLE.
- IDLE: in_ready=1. Transfer on in_valid&in_ready: capture, go SHIFT if clamped diff>0, else DONE.
- Magnitude compare on {exp,frac} unsigned; swap=1 iff mag_a < mag_b; equal magnitudes -> swap=0.
- Hidden bit = (exp != 0). Effective exponent = exp, or 1 when exp==0 (subnormal).
- diff = eff_exp_big - eff_exp_small, clamped to MAN_W+4 (remaining-count register width ceil(log2(MAN_W+5))).
- small register loaded with {hidden, frac, 3'b000}; big_man loaded likewise, never shifted.
- SHIFT: s = min(remaining, STEP); small <= small >> s; bit 0 (S) <= OR of old S and all bits shifted out (see Configuration); remaining -= s; remaining reaching 0 -> DONE.
- DONE: out_valid=1, outputs stable; out_valid&out_ready -> IDLE. No new operand accepted until IDLE (single-entry, no overlap).
- Infinities/NaNs not special-cased; treated as ordinary encodings.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE, in-flight operation discarded.

## Timing
- Reset values: out_valid=0, swap=0, res_sign=0, eff_sub=0, res_exp=0, big_man=0, small_man=0; in_ready=1 (state IDLE); no transfer while rst high.
- Latency accept edge -> out_valid high: 1 cycle if clamped diff=0, else 1+ceil(diff_clamped/STEP) cycles.
- Max latency 1+ceil((MAN_W+4)/STEP); defaults: 5 cycles.
- out_valid stays high and all outputs hold while out_ready=0.
- in_ready is 0 in the cycle out_valid&out_ready completes; earliest next accept is the following cycle (IDLE).
- Throughput: one result per latency+1 cycles at best.

## Configuration
- FP_ALIGN_STICKY_EN defined: S bit accumulates OR of all bits shifted past bit 0, exact sticky semantics.
- Not defined: shifted-out bits discarded; S shifts as an ordinary bit (G,R still present); no OR-reduction logic built.

## Test plan
- Defaults, op_a=0x3C00, op_b=0x3C00 -> swap=0, res_exp=0x0F, big_man=small_man=0x2000, eff_sub=0, out_valid 1 cycle after accept.
- op_a=0x3C00, op_b=0x4000 -> swap=1, res_exp=0x10, big_man=0x2000, small_man=0x1000, out_valid 2 cycles after accept.
- op_a=0x4C00, op_b=0x3C01 (diff 4) -> small_man=0x0201 with FP_ALIGN_STICKY_EN, 0x0200 without; 1 SHIFT cycle.
- op_a=0x7800, op_b=0x8001 (subnormal, diff 29 clamped to 14) -> small_man=0x0001 with sticky (0x0000 without), eff_sub=1, res_sign=0, out_valid 5 cycles after accept.
- Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new data -> outputs unchanged, in_ready=0, new data not captured; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst during SHIFT of scenario 4 -> out_valid=0, all data outputs 0, in_ready=1 immediately; after release a fresh 0x3C00/0x3C00 completes correctly.
